// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding, lane count and the
// address-window check used when WB_RAM_ERR_EN is defined.
package wb_pkg;

  localparam int WB_XLEN  = 32;
  localparam int WB_SEL_W = WB_XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_slave_state_t;

  // Upper bound is formed one bit wider so a window ending at the top of the
  // address space does not wrap to zero.
  function automatic logic in_range(input logic [WB_XLEN-1:0] addr,
                                    input logic [WB_XLEN-1:0] base,
                                    input logic [WB_XLEN:0]   bytes);
    logic [WB_XLEN:0] limit;
    limit = {1'b0, base} + bytes;
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/wishbone.sv
// Wishbone B4 classic bus bundle with master and slave views.
interface wishbone #(
  parameter int XLEN = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [XLEN-1:0]   adr;
  logic [XLEN/8-1:0] sel;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic              ack;
  logic              err;

  modport MASTER (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
  modport SLAVE  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_data_ram_ram_bank.sv
// Single-port byte-enabled synchronous RAM; the read register only updates
// when re is high so it doubles as the held bus read-data register.
module ram_bank #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     re,
  input  logic [XLEN/8-1:0]        we_lanes,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem_r [DEPTH];

  // Lane-masked write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < XLEN / 8; i++) begin
      if (we_lanes[i]) begin
        mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Full-word read register, held between read responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {XLEN{1'b0}};
    end else if (re) begin
      rdata <= mem_r[idx];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/wb_data_ram.sv
// Wishbone B4 classic data RAM with WAIT_STATES extra response cycles.
// Define WB_RAM_ERR_EN to answer out-of-window accesses with err instead of aliasing.
module wb_data_ram
  import wb_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0001_0000,
  parameter int              WAIT_STATES = 0
) (
  input logic    clk,
  input logic    rst,
  wishbone.SLAVE mm_bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int SEL_W = XLEN / 8;
  localparam int CNT_W = 4;

  wb_slave_state_t   state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ack_r;
  logic              err_r;
  logic [XLEN-1:0]   adr_r;
  logic              we_r;
  logic [SEL_W-1:0]  sel_r;
  logic [XLEN-1:0]   dat_w_r;
  logic              hit_s;
  logic              re_s;
  logic [SEL_W-1:0]  we_lanes_s;
  logic [XLEN-1:0]   rdata_s;
  logic              unused_adr_s;

`ifdef WB_RAM_ERR_EN
  assign hit_s = in_range(adr_r, BASE_ADDR, (WB_XLEN+1)'(DEPTH_WORDS * SEL_W));
`else
  assign hit_s = 1'b1;
`endif

  assign unused_adr_s = ^{adr_r[1:0], adr_r[XLEN-1:IDX_W+2]};

  // Request sequencing: accept, count wait states, single-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mm_bus.cyc && mm_bus.stb) begin
            adr_r   <= mm_bus.adr;
            we_r    <= mm_bus.we;
            sel_r   <= mm_bus.sel;
            dat_w_r <= mm_bus.dat_w;
            if (WAIT_STATES == 0) begin
              state_r <= RESP;
            end else begin
              state_r <= WAIT;
              cnt_r   <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!mm_bus.cyc) begin
            state_r <= IDLE;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          state_r <= IDLE;
          if (mm_bus.cyc) begin
            ack_r <= hit_s;
            err_r <= !hit_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Memory strobes fire on the response edge only while the master still holds cyc.
  always_comb begin
    re_s       = 1'b0;
    we_lanes_s = {SEL_W{1'b0}};
    if (state_r == RESP && mm_bus.cyc && hit_s) begin
      if (we_r) begin
        we_lanes_s = sel_r;
      end else begin
        re_s = 1'b1;
      end
    end else begin
      re_s       = 1'b0;
      we_lanes_s = {SEL_W{1'b0}};
    end
  end

  ram_bank #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH_WORDS)
  ) u_ram_bank (
    .clk      (clk),
    .rst      (rst),
    .re       (re_s),
    .we_lanes (we_lanes_s),
    .idx      (adr_r[IDX_W+1:2]),
    .wdata    (dat_w_r),
    .rdata    (rdata_s)
  );

  assign mm_bus.ack   = ack_r;
  assign mm_bus.err   = err_r;
  assign mm_bus.dat_r = rdata_s;

endmodule
